// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in, adds them one bit per
// clock LSB-first, and publishes sum and carry-out together with a single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start_i; operands and results hold
// RUN   | one bit per edge, counter tracks bit index
// DONE  | one-cycle result-valid pulse, returns to IDLE
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             C_i,
    output logic [WIDTH-1:0] S_o,
    output logic             C_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;
    logic load, step, last;

    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] psum_q;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic ha1_s, ha1_c, ha2_c, sum_bit, carry_nxt;

    // Full adder as two cascaded half adders
    assign ha1_s     = a_q[0] ^ b_q[0];
    assign ha1_c     = a_q[0] & b_q[0];
    assign sum_bit   = ha1_s ^ carry_q;
    assign ha2_c     = ha1_s & carry_q;
    assign carry_nxt = ha1_c | ha2_c;

    // Partial sum keeps only WIDTH-1 bits; the final bit joins it on the last edge
    assign psum_nxt  = {sum_bit, psum_q};
    assign last      = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            S_o     <= '0;
            C_o     <= 1'b0;
        end else if (load) begin
            a_q     <= A_i;
            b_q     <= B_i;
            carry_q <= C_i;
            cnt_q   <= '0;
        end else if (step) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            psum_q  <= psum_nxt[WIDTH-1:1];
            carry_q <= carry_nxt;
            cnt_q   <= cnt_q + 1'b1;
            if (last) begin
                S_o <= psum_nxt;
                C_o <= carry_nxt;
            end
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rstn;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             ci;
    logic [WIDTH-1:0] s_out;
    logic             c_out, busy, done;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .start_i (start),
        .A_i     (a),
        .B_i     (b),
        .C_i     (ci),
        .S_o     (s_out),
        .C_o     (c_out),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request keeps the block busy for WIDTH+1 cycles,
    // the last of which is the done cycle, when the new sum becomes visible.
    int               left    = 0;
    bit               m_valid = 0;
    logic [WIDTH-1:0] m_s     = '0;
    logic             m_c     = 1'b0;
    logic [WIDTH:0]   m_pend  = '0;

    always @(posedge clk) begin
        m_valid = 1;
        if (!rstn) begin
            left = 0;
            m_s  = '0;
            m_c  = 1'b0;
        end else if (left == 0) begin
            if (start) begin
                m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                left   = WIDTH + 1;
            end
        end else begin
            left--;
            if (left == 1) {m_c, m_s} = m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_s",    32'(s_out), 32'(m_s));
            chk("cyc_c",    32'(c_out), 32'(m_c));
            chk("cyc_busy", 32'(busy),  32'(left != 0));
            chk("cyc_done", 32'(done),  32'(left == 1));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] prev_s = '0;
    logic             prev_c = 1'b0;

    task automatic add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tc, input logic [WIDTH-1:0] es, input logic ec);
        int n;
        start = 1'b1; a = ta; b = tb; ci = tc;
        cyc(1);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
        chk("hold_s", 32'(s_out), 32'(prev_s));
        chk("hold_c", 32'(c_out), 32'(prev_c));
        n = 0;
        while (!done && n < 40) begin
            cyc(1);
            n++;
        end
        chk("latency", 32'(n), 32'(WIDTH));
        chk("res_s", 32'(s_out), 32'(es));
        chk("res_c", 32'(c_out), 32'(ec));
        chk("model_s", 32'(m_s), 32'(es));
        chk("done_busy", 32'(busy), 32'd1);
        prev_s = es;
        prev_c = ec;
        cyc(1);
    endtask

    initial begin
        logic [WIDTH:0] exp_sum;
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        int last_done, ndone;

        rstn = 1'b0; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        cyc(2);
        chk("rst_s", 32'(s_out), 32'd0);
        chk("rst_c", 32'(c_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // first edge with reset released must accept start
        rstn = 1'b1;
        add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        add(8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);
        add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // start held high with operands changing every cycle
        start = 1'b1;
        last_done = -1;
        for (int k = 0; k < 52; k++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
            cyc(1);
            if (done) begin
                if (last_done >= 0) chk("done_period", 32'(k - last_done), 32'd10);
                last_done = k;
            end
        end
        start = 1'b0;
        cyc(12);

        // reset while bit 4 is being processed
        start = 1'b1; a = 8'hAA; b = 8'h55; ci = 1'b0;
        cyc(1);
        start = 1'b0;
        cyc(4);
        rstn = 1'b0;
        cyc(1);
        rstn = 1'b1;
        chk("abort_s", 32'(s_out), 32'd0);
        chk("abort_c", 32'(c_out), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        prev_s = '0;
        prev_c = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            exp_sum = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            add(ra, rb, rc, exp_sum[WIDTH-1:0], exp_sum[WIDTH]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits, legal range 2..32.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  reset; synchronous, active-low, sampled on rising edge of clk_i.
REQ-004 start_i  input  1  request to add; sampled only in IDLE.
REQ-005 A_i  input  WIDTH  operand A, captured on the accepted start_i edge.
REQ-006 B_i  input  WIDTH  operand B, captured on the accepted start_i edge.
REQ-007 C_i  input  1  carry-in, captured on the accepted start_i edge.
REQ-008 S_o  output  WIDTH  registered sum of the last completed addition.
REQ-009 C_o  output  1  registered carry-out of the last completed addition.
REQ-010 busy_o  output  1  high in RUN and DONE states.
REQ-011 done_o  output  1  one-cycle pulse, high only in DONE state.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 In IDLE, start_i=1 at a rising edge SHALL load A_i, B_i into operand shift registers, C_i into the carry flop, clear the bit counter, and enter RUN.
REQ-014 In IDLE with start_i=0, state, operand registers, S_o and C_o SHALL hold.
REQ-015 In RUN, each rising edge SHALL process one bit LSB-first: sum bit = a0 XOR b0 XOR carry; new carry = majority(a0, b0, carry), i.e. two cascaded half-adder stages plus OR.
REQ-016 In RUN, each edge SHALL shift both operand registers right by one, shift the sum bit into the MSB of the partial-sum register, and increment the counter.
REQ-017 On the RUN edge where the counter equals WIDTH-1, the block SHALL load the full partial sum into S_o, the final carry into C_o, and enter DONE.
REQ-018 S_o and C_o SHALL change only on entry to DONE or on reset, never during RUN.
REQ-019 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE unconditionally.
REQ-020 Latency: done_o SHALL be high in the cycle following the WIDTH-th rising edge after the start-accepting edge (WIDTH+1 edges from start sampling to done_o).
REQ-021 start_i SHALL be ignored in RUN and DONE; operands in flight SHALL not be disturbed.
REQ-022 A start_i asserted in the DONE cycle SHALL be ignored; start_i high in the following IDLE cycle SHALL be accepted (minimum initiation interval WIDTH+2 cycles).
REQ-023 Result SHALL equal (A + B + C_i) mod 2^(WIDTH+1), with bit WIDTH on C_o, for all operand values including all-ones.
REQ-024 A_i, B_i, C_i SHALL be don't-care in every cycle except the start-accepting edge.

Reset
REQ-025 rstn_i=0 at a rising edge SHALL force state IDLE, counter 0, carry 0, operand and partial-sum registers 0, S_o=0, C_o=0, busy_o=0, done_o=0.
REQ-026 Reset SHALL take priority over start_i and over any RUN/DONE activity; reset mid-RUN SHALL abort the addition with no done_o pulse and S_o/C_o=0.
REQ-027 The first start_i SHALL be accepted on the first rising edge with rstn_i=1.

Verification (WIDTH=8)
REQ-028 A=0x00, B=0x00, C_i=0, start 1 cycle -> done_o after 9 edges, S_o=0x00, C_o=0, busy_o high 9 cycles.
REQ-029 A=0xFF, B=0x01, C_i=0 -> S_o=0x00, C_o=1; S_o unchanged during RUN from previous result.
REQ-030 A=0x3C, B=0x42, C_i=1 -> S_o=0x7F, C_o=0; A=0xFF, B=0xFF, C_i=1 -> S_o=0xFF, C_o=1.
REQ-031 start_i held high continuously with A_i/B_i changing every cycle -> each result matches operands at accepting edge; done_o pulses every 10 cycles.
REQ-032 rstn_i low 1 cycle at RUN bit 4 of A=0xAA, B=0x55 -> no done_o, S_o=0x00, C_o=0, busy_o=0 next cycle.
REQ-033 Exhaustive/random check of 1000 (A, B, C_i) triples against A+B+C_i reference model; zero mismatches.
